// File: rtl/aidc_lite_comp_pkg.sv
// ----------------------------------------------------------------------------
// aidc_lite_comp_pkg
//
// Shared definitions for the compressor result selector:
//   sel_state_t    : selector FSM state encoding
//   SEL_SR         : selection code for the SR compressor
//   SEL_ZRLE       : selection code for the ZRLE compressor
//   SEL_NONE       : selection code when no compressor result is usable
//   COMP_BUF_DEPTH : entries per compressor result buffer
// ----------------------------------------------------------------------------
package aidc_lite_comp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_SELECT  = 3'd3,
        ST_READ    = 3'd4
    } sel_state_t;

    localparam logic [1:0] SEL_SR   = 2'd0;
    localparam logic [1:0] SEL_ZRLE = 2'd1;
    localparam logic [1:0] SEL_NONE = 2'd3;

    localparam int COMP_BUF_DEPTH = 16;

endpackage

// File: rtl/aidc_lite_comp_size_trk.sv
// ----------------------------------------------------------------------------
// aidc_lite_comp_size_trk
//
// Tracks how many result-buffer entries one compressor has written for the
// current block. The count is the highest written address plus one, so it
// is insensitive to the order in which the compressor writes its entries.
//
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset
//   clr    : clear the count (block start)
//   en     : writes are counted only while this is high
//   wren   : buffer write strobe
//   waddr  : buffer write address
//   cnt    : entries written so far (0..BUF_DEPTH)
// ----------------------------------------------------------------------------
module aidc_lite_comp_size_trk #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          wren,
    input  logic [AW-1:0] waddr,
    output logic [AW:0]   cnt
);

    logic [AW:0] addr_plus1;

    assign addr_plus1 = {1'b0, waddr} + {{AW{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && wren && (addr_plus1 > cnt)) begin
            cnt <= addr_plus1;
        end
    end

endmodule

// File: rtl/aidc_lite_comp_sel.sv
// ----------------------------------------------------------------------------
// aidc_lite_comp_sel
//
// Result selector and drain stage behind the SR and ZRLE compressors. While a
// block is being compressed it tracks how many buffer entries each compressor
// wrote; once the compressors have flushed it picks the smallest non-failed
// result and serves it to the engine as a stream of 32-bit words.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   sop_i, eop_i          : engine block start / block end strobes
//   c0_wren_i, c0_waddr_i : SR result buffer write strobe / address
//   c0_fail_i             : SR failed (sampled when the decision is made)
//   c1_wren_i, c1_waddr_i : ZRLE result buffer write strobe / address
//   c1_fail_i             : ZRLE failed (sampled when the decision is made)
//   c0_raddr_o, c0_rdata_i: SR buffer read port (data 1 cycle after address)
//   c1_raddr_o, c1_rdata_i: ZRLE buffer read port (data 1 cycle after address)
//   ready_o               : a result is selected and readable
//   sel_o                 : selected compressor (SEL_SR / SEL_ZRLE / SEL_NONE)
//   fail_o                : both compressors failed, block goes uncompressed
//   len_o                 : result length in 32-bit words
//   rden_i                : engine read request, one word per cycle
//   rvalid_o, rdata_o     : read word and its valid, 1 cycle after rden_i
//   state_o               : current FSM state, for observation
//
// Read handshake: a word request is accepted in any cycle where rden_i = 1,
// ready_o = 1, the FSM is in READ and fewer than len_o words have been taken.
// Exactly one cycle after each accepted request rvalid_o = 1 with that word
// on rdata_o; there is no back-pressure on the return path, and a request
// that is not accepted produces nothing (rdata_o stays 0 while rvalid_o = 0).
// ----------------------------------------------------------------------------
module aidc_lite_comp_sel
    import aidc_lite_comp_pkg::*;
#(
    parameter int DRAIN_LAT = 2,
    parameter int BUF_DEPTH = COMP_BUF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sop_i,
    input  logic                         eop_i,
    input  logic                         c0_wren_i,
    input  logic [$clog2(BUF_DEPTH)-1:0] c0_waddr_i,
    input  logic                         c0_fail_i,
    input  logic                         c1_wren_i,
    input  logic [$clog2(BUF_DEPTH)-1:0] c1_waddr_i,
    input  logic                         c1_fail_i,
    output logic [$clog2(BUF_DEPTH)-1:0] c0_raddr_o,
    input  logic [63:0]                  c0_rdata_i,
    output logic [$clog2(BUF_DEPTH)-1:0] c1_raddr_o,
    input  logic [63:0]                  c1_rdata_i,
    output logic                         ready_o,
    output logic [1:0]                   sel_o,
    output logic                         fail_o,
    output logic [$clog2(BUF_DEPTH)+1:0] len_o,
    input  logic                         rden_i,
    output logic                         rvalid_o,
    output logic [31:0]                  rdata_o,
    output sel_state_t                   state_o
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int LW = AW + 2;
    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_LAT - 1);

    sel_state_t    state;
    logic [2:0]    dcnt;
    logic [1:0]    sel_q;
    logic          fail_q;
    logic [LW-1:0] len_q;
    logic          ready_q;
    logic [LW-1:0] rp;
    logic          half_q;
    logic          rvalid_q;

    logic [AW:0]   cnt0;
    logic [AW:0]   cnt1;
    logic          trk_en;

    logic          elig0;
    logic          elig1;
    logic [1:0]    pick_sel;
    logic [AW:0]   pick_cnt;

    logic          rd_accept;
    logic [63:0]   sel_word;

    // Compressor writes still land in the buffers during DRAIN (their
    // pipelines flush after eop), so both phases are counted.
    assign trk_en = (state == ST_COLLECT) || (state == ST_DRAIN);

    aidc_lite_comp_size_trk #(.AW(AW)) u_trk_sr (
        .clk   (clk),
        .rst   (rst),
        .clr   (sop_i),
        .en    (trk_en),
        .wren  (c0_wren_i),
        .waddr (c0_waddr_i),
        .cnt   (cnt0)
    );

    aidc_lite_comp_size_trk #(.AW(AW)) u_trk_zrle (
        .clk   (clk),
        .rst   (rst),
        .clr   (sop_i),
        .en    (trk_en),
        .wren  (c1_wren_i),
        .waddr (c1_waddr_i),
        .cnt   (cnt1)
    );

    // Smallest usable result wins; SR wins ties.
    assign elig0 = !c0_fail_i && (cnt0 != '0);
    assign elig1 = !c1_fail_i && (cnt1 != '0);

    always_comb begin
        pick_sel = SEL_NONE;
        pick_cnt = '0;
        if (elig0 && (!elig1 || (cnt0 <= cnt1))) begin
            pick_sel = SEL_SR;
            pick_cnt = cnt0;
        end else if (elig1) begin
            pick_sel = SEL_ZRLE;
            pick_cnt = cnt1;
        end
    end

    // With no usable result len_q is 0, so nothing is ever accepted.
    assign rd_accept = (state == ST_READ) && ready_q && rden_i && (rp < len_q);

    // FSM plus all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            dcnt     <= '0;
            sel_q    <= SEL_NONE;
            fail_q   <= 1'b0;
            len_q    <= '0;
            ready_q  <= 1'b0;
            rp       <= '0;
            half_q   <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_accept;
            if (rd_accept) begin
                half_q <= rp[0];
                rp     <= rp + LW'(1);
            end

            if (sop_i) begin
                // A new block aborts whatever was in progress.
                rp      <= '0;
                ready_q <= 1'b0;
                dcnt    <= '0;
                state   <= eop_i ? ST_DRAIN : ST_COLLECT;
            end else begin
                case (state)
                    ST_IDLE: begin
                    end
                    ST_COLLECT: begin
                        if (eop_i) begin
                            dcnt  <= '0;
                            state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (dcnt == DRAIN_LAST) begin
                            state <= ST_SELECT;
                        end else begin
                            dcnt <= dcnt + 3'd1;
                        end
                    end
                    ST_SELECT: begin
                        sel_q   <= pick_sel;
                        fail_q  <= (pick_sel == SEL_NONE);
                        len_q   <= {pick_cnt, 1'b0};
                        ready_q <= 1'b1;
                        rp      <= '0;
                        state   <= ST_READ;
                    end
                    ST_READ: begin
                        // The failed case never accepts, so it stays here
                        // with ready_q high until the next block start.
                        if (rd_accept && ((rp + LW'(1)) == len_q)) begin
                            ready_q <= 1'b0;
                            state   <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Each 64-bit entry holds two words: word rp lives in entry rp/2.
    assign c0_raddr_o = (rd_accept && (sel_q == SEL_SR))   ? rp[AW:1] : '0;
    assign c1_raddr_o = (rd_accept && (sel_q == SEL_ZRLE)) ? rp[AW:1] : '0;

    always_comb begin
        sel_word = '0;
        rdata_o  = '0;
        if (rvalid_q) begin
            sel_word = (sel_q == SEL_ZRLE) ? c1_rdata_i : c0_rdata_i;
            rdata_o  = half_q ? sel_word[63:32] : sel_word[31:0];
        end
    end

    assign ready_o  = ready_q;
    assign sel_o    = sel_q;
    assign fail_o   = fail_q;
    assign len_o    = len_q;
    assign rvalid_o = rvalid_q;
    assign state_o  = state;

endmodule
